// File: rtl/lsu_ext_resp.sv
// lsu_ext_resp: target end of the LSU external-access port.
// Accepts one request at a time, waits WAIT_CYC cycles, then serves it from an
// internal word-addressed memory and returns a one-cycle completion strobe.
module lsu_ext_resp #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADR   = 32'h8000_0000,
  parameter int          WAIT_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_val,
  output logic        o_rdy,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_wdat,
  input  logic [3:0]  i_wen,
  input  logic        i_ren,
  output logic [31:0] o_rdat,
  output logic        o_err,
  output logic        o_busy
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:2] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  wen_q, wen_d;
  logic        ren_q, ren_d;
  logic        rdy_q, rdy_d;
  logic [31:0] rdat_q, rdat_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  // The access may happen straight out of IDLE when there are no wait
  // states, so the request is taken from the ports in IDLE, else from the latch.
  logic [31:2]           acc_adr;
  logic [31:0]           acc_wdat;
  logic [3:0]            acc_wen;
  logic                  acc_ren;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_in_win;
  logic [31:0]           mem_rd;
  logic                  mem_we;

  // Byte-offset bits carry no meaning for a word-wide memory.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^i_adr[1:0];

  // Select the request payload that the memory access will use.
  always_comb begin
    if (state_q == IDLE) begin
      acc_adr  = i_adr[31:2];
      acc_wdat = i_wdat;
      acc_wen  = i_wen;
      acc_ren  = i_ren;
    end else begin
      acc_adr  = adr_q;
      acc_wdat = wdat_q;
      acc_wen  = wen_q;
      acc_ren  = ren_q;
    end
    acc_idx    = acc_adr[DEPTH_LOG2+1:2];
    acc_in_win = (acc_adr[31:DEPTH_LOG2+2] == BASE_ADR[31:DEPTH_LOG2+2]);
    mem_rd     = mem[acc_idx];
  end

  // Next-state, latch and response computation for the request FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    rdy_d   = 1'b0;
    rdat_d  = 32'd0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_val) begin
          adr_d  = i_adr[31:2];
          wdat_d = i_wdat;
          wen_d  = i_wen;
          ren_d  = i_ren;
          if (WAIT_CYC == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == RESP && state_q != RESP) begin
      rdy_d  = 1'b1;
      err_d  = ~acc_in_win;
      mem_we = acc_in_win && (acc_wen != 4'd0);
      if (acc_in_win && acc_wen == 4'd0 && acc_ren) begin
        rdat_d = mem_rd;
      end
    end
  end

  // Register FSM state, latched request and the registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      wdat_q  <= 32'd0;
      wen_q   <= 4'd0;
      ren_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rdat_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      rdy_q   <= rdy_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  // Commit enabled byte lanes on the edge entering RESP; a reset on that edge cancels it.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (acc_wen[k]) begin
          mem[acc_idx][8*k +: 8] <= acc_wdat[8*k +: 8];
        end
      end
    end
  end

  assign o_rdy  = rdy_q;
  assign o_rdat = rdat_q;
  assign o_err  = err_q;
  assign o_busy = (state_q != IDLE);

endmodule

// File: doc/lsu_ext_resp.md
Name: lsu_ext_resp

Overview:
- Responder (target) end of the LSU external-access interface (the LSU's ls4axim val/rdy request port).
- Accepts one blocking request at a time from the LSU: address, write data, byte write enables and read enable.
- Serves the request from an internal word-addressed memory after a programmable number of wait cycles.
- Returns completion with read data and an out-of-range error flag. Acts as the external data memory and wait-state model the core's external bus talks to.

Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (10 = 4 KiB window).
- BASE_ADR, 32'h8000_0000, window base address; must be aligned to 2^(DEPTH_LOG2+2).
- WAIT_CYC, 2, wait states inserted between acceptance and completion (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_val  in  1  request valid from LSU (hs_ls4axim_val).
- o_rdy  out  1  completion strobe to LSU (hs_axim4ls_rdy); one-cycle pulse.
- i_adr  in  32  byte address.
- i_wdat  in  32  write data, byte lanes aligned to address bits [1:0]=0.
- i_wen  in  4  byte write enables; nonzero = write.
- i_ren  in  1  read enable.
- o_rdat  out  32  read data, valid when o_rdy=1.
- o_err  out  1  address outside window; valid when o_rdy=1.
- o_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset is synchronous and active-high. Reset drives state to IDLE and clears the wait counter, o_rdy, o_rdat and o_err. Memory contents are not reset; they are undefined at power-up.
- FSM states:
  - IDLE: if i_val=1, latch adr/wdat/wen/ren. Then go to WAIT with cnt=WAIT_CYC-1, or go directly to RESP when WAIT_CYC=0.
  - WAIT: decrement cnt. When cnt==0, go to RESP.
  - RESP: o_rdy=1 for exactly one cycle, then return to IDLE.
- Latency: i_val sampled in IDLE at edge T gives o_rdy=1 in cycle T+1+WAIT_CYC.
- Memory access happens on the edge entering RESP:
  - word index = adr[DEPTH_LOG2+1:2].
  - in-window test: adr[31:DEPTH_LOG2+2] == BASE_ADR[31:DEPTH_LOG2+2].
  - adr[1:0] is ignored.
- Write (latched wen≠0):
  - in-window: each lane k with wen[k]=1 is updated from wdat[8k+7:8k]; other lanes are unchanged. o_rdat=0.
- Read (wen==0, ren=1):
  - in-window: o_rdat=mem[idx].
- wen≠0 together with ren=1: treated as a write only; o_rdat=0.
- Null request (wen==0, ren=0): completes normally with no memory effect, o_rdat=0, o_err=0.
- Out of window: no memory change, o_rdat=0, o_err=1. This applies to reads, writes and null requests alike.
- o_rdat and o_err are registered and held stable while o_rdy=1. Both return to 0 in the cycle after RESP.
- Input changes after latching (during WAIT/RESP) are ignored.
- LSU protocol:
  - The LSU holds i_val and payload until it sees o_rdy.
  - If i_val is still 1 in the IDLE cycle following RESP, it is a new request and is accepted. Back-to-back throughput is one request per WAIT_CYC+2 cycles.
  - No request is lost or serviced twice.
- i_val deasserted while not IDLE: ignored; the latched request still completes.
- Reset mid-operation (WAIT or RESP): the pending request is abandoned and no o_rdy pulse is issued. A write not yet committed is not performed; one already committed stays committed.

Test Plan (WAIT_CYC=2, BASE_ADR=32'h8000_0000, DEPTH_LOG2=10):
1. Write 32'h1234_5678, wen=4'hF, adr 32'h8000_0010, accepted at T -> o_rdy only at T+3, o_err=0. Then read same adr -> o_rdy at +3, o_rdat=32'h1234_5678.
2. Byte write wen=4'b0010, wdat 32'h0000_AB00 to 32'h8000_0010; adr 32'h8000_0012 then read -> o_rdat=32'h1234_AB78 (adr[1:0] ignored).
3. Read 32'h4000_0000 -> o_rdy at T+3, o_err=1, o_rdat=0. Write 32'hFFFF_FFFF to 32'h8000_1010 (out of window) -> o_err=1; read 32'h8000_0010 -> still 32'h1234_AB78.
4. i_val held high across two reads of 32'h8000_0010 and 32'h8000_0014 -> o_rdy pulses exactly at T+3 and T+7, data matches each address, o_busy low only in cycles T+4/T+8.
5. During WAIT, change i_adr to 32'h8000_0014 and drop i_val -> completion still returns mem[4]'s data for the originally latched 32'h8000_0010. Null request (wen=0, ren=0) -> o_rdy at T+3, o_rdat=0, o_err=0.
6. Assert rst in WAIT of a write to 32'h8000_0020 -> no o_rdy, outputs 0, o_busy=0; next read of 32'h8000_0010 completes normally. Separate build with WAIT_CYC=0 -> o_rdy at T+1.
